// File: rtl/valid_ready_fifo.sv
// Elastic FWFT buffer: valid-only input, valid/ready output, drops and flags words arriving while full.
// Optional VRFIFO_DROP_CNT_EN adds a saturating 16-bit drop_count output.
module valid_ready_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  input  logic                     clr_overflow
`ifdef VRFIFO_DROP_CNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = w_valid & out_ready;
  // A pop on a full buffer frees the slot the incoming word lands in.
  assign w_push  = in_valid & (~w_full | w_pop);
  assign w_drop  = in_valid & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Set beats clear when both occur in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_overflow <= 1'b0;
    else if (w_drop)       r_overflow <= 1'b1;
    else if (clr_overflow) r_overflow <= 1'b0;
  end

`ifdef VRFIFO_DROP_CNT_EN
  logic [15:0] r_drop_count;

  // Clear wins here: a drop coinciding with clr_overflow is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_drop_count <= '0;
    else if (clr_overflow)                    r_drop_count <= '0;
    else if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
  end

  assign drop_count = r_drop_count;
`endif

  assign out_valid = w_valid;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign out_data  = w_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_valid_ready_fifo.sv
// Directed bench for valid_ready_fifo: vector table plus hand-written multi-cycle sequences.
module tb_valid_ready_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             overflow;
  logic             clr_overflow;
`ifdef VRFIFO_DROP_CNT_EN
  logic [15:0]      drop_count;
`endif

  int checks = 0;
  int errors = 0;

  valid_ready_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef VRFIFO_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    int         c;
    logic       v;
    logic       f;
    logic       o;
    logic [7:0] q;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] d, input logic rdy, input logic clr);
    in_valid     = iv;
    in_data      = d;
    out_ready    = rdy;
    clr_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int c, input logic v, input logic f,
                         input logic o, input logic [7:0] q);
    chk({tag, ".count"},    int'(count),     c);
    chk({tag, ".valid"},    int'(out_valid), int'(v));
    chk({tag, ".full"},     int'(full),      int'(f));
    chk({tag, ".overflow"}, int'(overflow),  int'(o));
    chk({tag, ".data"},     int'(out_data),  int'(q));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // iv  data   rdy  clr  count valid full ovf  data
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h11};
    tbl[2]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 8'h11};
    tbl[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 8'h11};
    tbl[4]  = '{1'b1, 8'h44, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 8'h11};
    tbl[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b0, 8'h11};
    tbl[7]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 8'h22};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 8'h33};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 8'h44};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'hAA};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00};

    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    do_reset();
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].c, tbl[i].v, tbl[i].f, tbl[i].o, tbl[i].q);
    end

    // Streaming 0..19 through an empty buffer; pointers wrap five times.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      chk($sformatf("stream%0d.count", i), int'(count), 1);
      chk($sformatf("stream%0d.data", i), int'(out_data), i);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_end.valid", int'(out_valid), 0);

    // Mid-cycle reset with two words buffered.
    step(1'b1, 8'hE1, 1'b0, 1'b0);
    step(1'b1, 8'hE2, 1'b0, 1'b0);
    chk("pre_rst.count", int'(count), 2);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.valid", int'(out_valid), 0);
    chk("async_rst.count", int'(count), 0);
    chk("async_rst.data", int'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("post_rst.data", int'(out_data), 8'h77);
    chk("post_rst.count", int'(count), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst.empty", int'(out_valid), 0);

    // Fill, then drops; set must beat a simultaneous clear.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("refill.full", int'(full), 1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hDD, 1'b0, 1'b0);
    chk("drops.overflow", int'(overflow), 1);
    chk("drops.count", int'(count), 4);
    chk("drops.head", int'(out_data), 8'h60);
`ifdef VRFIFO_DROP_CNT_EN
    chk("drop_count3", int'(drop_count), 3);
`endif
    step(1'b1, 8'hDD, 1'b0, 1'b1);
    chk("set_wins.overflow", int'(overflow), 1);
`ifdef VRFIFO_DROP_CNT_EN
    chk("clr_drop_count", int'(drop_count), 0);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clear.overflow", int'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("drain%0d.count", i), int'(count), 3 - i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
